// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: parametrised synchronous data memory with a valid/ready
// request port and a fixed-latency (RD_LAT = 1 or 2) response port.
// After every reset a self-initialisation sweep loads mem[i] = i, then one
// read or write is served per cycle.
// Optional build macro: DMEM_PARITY_EN adds a per-word even-parity bit,
// the err_inject input and the rsp_perr output.
module data_mem_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
`ifdef DMEM_PARITY_EN
    input  logic              err_inject,
    output logic              rsp_perr,
`endif
    output logic              init_busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
`ifdef DMEM_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned MEM_W = DATA_W + PAR_W;

    // Reject illegal configurations at elaboration
    generate
        if (!(RD_LAT == 1 || RD_LAT == 2)) begin : g_bad_rd_lat
            $fatal(1, "data_mem_ctrl: RD_LAT must be 1 or 2");
        end
        if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
            $fatal(1, "data_mem_ctrl: DEPTH must be in 1..2**ADDR_W");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_req_ready;
    logic               r_init_busy;

    logic [MEM_W-1:0]   r_mem [DEPTH];

    logic               w_accept;
    logic               w_in_range;
    logic               w_wr_en;
    logic [IDX_W-1:0]   w_addr_idx;
    logic [IDX_W-1:0]   w_cnt_idx;
    logic [DATA_W-1:0]  w_init_data;
    logic [MEM_W-1:0]   w_init_word;
    logic [MEM_W-1:0]   w_wr_word;
    logic [MEM_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]  w_rd_data;
    logic [DATA_W-1:0]  w_rsp_data;

    logic               r_s1_valid;
    logic [DATA_W-1:0]  r_s1_data;
    logic               r_s1_err;

    assign req_ready   = r_req_ready;
    assign init_busy   = r_init_busy;

    assign w_accept    = req_valid && r_req_ready;
    assign w_in_range  = CNT_W'(req_addr) < DEPTH_C;
    assign w_wr_en     = w_accept && req_we && w_in_range;
    assign w_addr_idx  = req_addr[IDX_W-1:0];
    assign w_cnt_idx   = r_cnt[IDX_W-1:0];
    assign w_init_data = DATA_W'(r_cnt);
    assign w_rd_word   = r_mem[w_addr_idx];
    assign w_rd_data   = w_rd_word[DATA_W-1:0];

`ifdef DMEM_PARITY_EN
    logic w_rsp_perr;
    logic r_s1_perr;
    assign w_init_word = {^w_init_data, w_init_data};
    assign w_wr_word   = {(^req_wdata) ^ err_inject, req_wdata};
    // Only in-range reads can flag a parity error; writes echo clean data
    assign w_rsp_perr  = w_in_range && !req_we &&
                         ((^w_rd_data) != w_rd_word[MEM_W-1]);
`else
    assign w_init_word = w_init_data;
    assign w_wr_word   = req_wdata;
`endif

    // Response payload: zero on out-of-range, write echo, or stored word
    assign w_rsp_data = !w_in_range ? '0 : (req_we ? req_wdata : w_rd_data);

    // Control FSM: INIT sweeps the counter once, RUN is held until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_init_busy <= 1'b1;
        end else if (r_state == S_INIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
                r_state     <= S_RUN;
                r_req_ready <= 1'b1;
                r_init_busy <= 1'b0;
            end
        end
    end

    // Storage: sweep writes during INIT, accepted in-range writes in RUN
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[w_cnt_idx] <= w_init_word;
        end else if (w_wr_en) begin
            r_mem[w_addr_idx] <= w_wr_word;
        end
    end

    // First response stage; payload only moves on accept so it holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_err   <= 1'b0;
`ifdef DMEM_PARITY_EN
            r_s1_perr  <= 1'b0;
`endif
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= w_rsp_data;
                r_s1_err  <= !w_in_range;
`ifdef DMEM_PARITY_EN
                r_s1_perr <= w_rsp_perr;
`endif
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_s2_valid;
            logic [DATA_W-1:0] r_s2_data;
            logic              r_s2_err;
`ifdef DMEM_PARITY_EN
            logic              r_s2_perr;
`endif

            // Second response stage for two-cycle latency
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                    r_s2_err   <= 1'b0;
`ifdef DMEM_PARITY_EN
                    r_s2_perr  <= 1'b0;
`endif
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                        r_s2_err  <= r_s1_err;
`ifdef DMEM_PARITY_EN
                        r_s2_perr <= r_s1_perr;
`endif
                    end
                end
            end

            assign rsp_valid = r_s2_valid;
            assign rsp_rdata = r_s2_data;
            assign rsp_err   = r_s2_err;
`ifdef DMEM_PARITY_EN
            assign rsp_perr  = r_s2_perr;
`endif
        end else begin : g_lat1
            assign rsp_valid = r_s1_valid;
            assign rsp_rdata = r_s1_data;
            assign rsp_err   = r_s1_err;
`ifdef DMEM_PARITY_EN
            assign rsp_perr  = r_s1_perr;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: two instances (RD_LAT=1 and RD_LAT=2) share
// one request stream; each response is checked on its own exact cycle.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;

    logic        rdy1, rv1, re1, busy1;
    logic [15:0] rd1;
    logic        rdy2, rv2, re2, busy2;
    logic [15:0] rd2;
`ifdef DMEM_PARITY_EN
    logic        err_inject;
    logic        perr1, perr2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [15:0] wdata;
        logic        inj;
        logic [15:0] exp_rdata;
        logic        exp_err;
        logic        exp_perr;
    } vec_t;

    vec_t q[$];
    vec_t tv[13];

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(6), .DEPTH(32), .RD_LAT(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (rdy1),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rv1),
        .rsp_rdata (rd1),
        .rsp_err   (re1),
`ifdef DMEM_PARITY_EN
        .err_inject(err_inject),
        .rsp_perr  (perr1),
`endif
        .init_busy (busy1)
    );

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(6), .DEPTH(32), .RD_LAT(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (rdy2),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rv2),
        .rsp_rdata (rd2),
        .rsp_err   (re2),
`ifdef DMEM_PARITY_EN
        .err_inject(err_inject),
        .rsp_perr  (perr2),
`endif
        .init_busy (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [5:0] a, input logic [15:0] wd,
                                input logic inj, input logic [15:0] ex, input logic er,
                                input logic pe);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.inj = inj;
        v.exp_rdata = ex; v.exp_err = er; v.exp_perr = pe;
        return v;
    endfunction

    // Compare one DUT's response port against request idx (or idle if none due)
    task automatic chk_rsp(input string tag, input int idx, input int n,
                           input logic v, input logic [15:0] d, input logic e, input logic p);
        if (idx >= 0 && idx < n) begin
            chk($sformatf("%s valid req%0d", tag, idx), 32'(v), 32'd1);
            chk($sformatf("%s rdata req%0d addr %0d", tag, idx, q[idx].addr), 32'(d), 32'(q[idx].exp_rdata));
            chk($sformatf("%s err req%0d addr %0d", tag, idx, q[idx].addr), 32'(e), 32'(q[idx].exp_err));
`ifdef DMEM_PARITY_EN
            chk($sformatf("%s perr req%0d addr %0d", tag, idx, q[idx].addr), 32'(p), 32'(q[idx].exp_perr));
`endif
        end else begin
            chk($sformatf("%s idle", tag), 32'(v), 32'd0);
        end
    endtask

    // Issue all queued requests back-to-back and check both response streams
    task automatic run_q();
        int n;
        n = q.size();
        for (int c = 0; c <= n + 2; c++) begin
            @(negedge clk);
            chk_rsp("lat1", c - 1, n, rv1, rd1, re1, perr_of(1));
            chk_rsp("lat2", c - 2, n, rv2, rd2, re2, perr_of(2));
            if (c < n) begin
                chk("ready at issue", 32'(rdy1 & rdy2), 32'd1);
                req_valid = 1'b1;
                req_we    = q[c].we;
                req_addr  = q[c].addr;
                req_wdata = q[c].wdata;
`ifdef DMEM_PARITY_EN
                err_inject = q[c].inj;
`endif
            end else begin
                req_valid = 1'b0;
                req_we    = 1'b0;
`ifdef DMEM_PARITY_EN
                err_inject = 1'b0;
`endif
            end
        end
        chk("lat1 rdata hold", 32'(rd1), 32'(q[n-1].exp_rdata));
        chk("lat2 rdata hold", 32'(rd2), 32'(q[n-1].exp_rdata));
        chk("lat1 err hold", 32'(re1), 32'(q[n-1].exp_err));
        chk("lat2 err hold", 32'(re2), 32'(q[n-1].exp_err));
        q.delete();
    endtask

    function automatic logic perr_of(input int which);
`ifdef DMEM_PARITY_EN
        return (which == 1) ? perr1 : perr2;
`else
        return (which == 1) ? 1'b0 : 1'b0;
`endif
    endfunction

    // Wait (bounded) for the INIT sweep after rst_n release; expect exactly 32 cycles
    task automatic wait_init(input string tag);
        int   n;
        logic last_busy;
        logic saw_rsp;
        n = 0; last_busy = 1'b0; saw_rsp = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            n = k;
            if (rv1 || rv2) saw_rsp = 1'b1;
            if (rdy1) break;
            last_busy = busy1 & busy2 & ~rdy2;
        end
        chk({tag, " init cycles"}, 32'(n), 32'd32);
        chk({tag, " ready lat2"}, 32'(rdy2), 32'd1);
        chk({tag, " busy low after init"}, 32'(busy1 | busy2), 32'd0);
        chk({tag, " busy during init"}, 32'(last_busy), 32'd1);
        chk({tag, " no rsp during init"}, 32'(saw_rsp), 32'd0);
    endtask

    initial begin
        // Single-request vectors, applied after the initial 0..31 read sweep
        tv[0]  = mk(1'b1, 6'd5,  16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        tv[1]  = mk(1'b0, 6'd5,  16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        tv[2]  = mk(1'b0, 6'd6,  16'h0000, 1'b0, 16'h0006, 1'b0, 1'b0);
        tv[3]  = mk(1'b1, 6'd40, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0);
        tv[4]  = mk(1'b0, 6'd40, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        tv[5]  = mk(1'b0, 6'd8,  16'h0000, 1'b0, 16'h0008, 1'b0, 1'b0);
        tv[6]  = mk(1'b1, 6'd31, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        tv[7]  = mk(1'b0, 6'd31, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        tv[8]  = mk(1'b0, 6'd32, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        tv[9]  = mk(1'b0, 6'd63, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        tv[10] = mk(1'b1, 6'd0,  16'hA5A5, 1'b0, 16'hA5A5, 1'b0, 1'b0);
        tv[11] = mk(1'b0, 6'd0,  16'h0000, 1'b0, 16'hA5A5, 1'b0, 1'b0);
        tv[12] = mk(1'b0, 6'd30, 16'h0000, 1'b0, 16'h001E, 1'b0, 1'b0);

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0;
`ifdef DMEM_PARITY_EN
        err_inject = 1'b0;
`endif

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("reset ready", 32'({rdy1, rdy2}), 32'd0);
        chk("reset rsp_valid", 32'({rv1, rv2}), 32'd0);
        chk("reset rdata lat1", 32'(rd1), 32'd0);
        chk("reset rdata lat2", 32'(rd2), 32'd0);
        chk("reset err", 32'({re1, re2}), 32'd0);
        chk("reset busy", 32'({busy1, busy2}), 32'd3);
`ifdef DMEM_PARITY_EN
        chk("reset perr", 32'({perr1, perr2}), 32'd0);
`endif
        rst_n = 1'b1;
        wait_init("first");

        // Full sweep read-back, fully pipelined
        for (int i = 0; i < 32; i++) q.push_back(mk(1'b0, 6'(i), 16'h0, 1'b0, 16'(i), 1'b0, 1'b0));
        run_q();

        // Table of isolated requests
        for (int i = 0; i < 13; i++) begin
            q.push_back(tv[i]);
            run_q();
        end

        // Back-to-back reads 3,4,7
        q.push_back(mk(1'b0, 6'd3, 16'h0, 1'b0, 16'h0003, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 6'd4, 16'h0, 1'b0, 16'h0004, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 6'd7, 16'h0, 1'b0, 16'h0007, 1'b0, 1'b0));
        run_q();

        // Back-to-back writes/reads: write then same-address read on the next cycle,
        // out-of-range write followed by a read of its would-be alias
        q.push_back(mk(1'b1, 6'd12, 16'hC0DE, 1'b0, 16'hC0DE, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 6'd12, 16'h0,    1'b0, 16'hC0DE, 1'b0, 1'b0));
        q.push_back(mk(1'b1, 6'd40, 16'h5555, 1'b0, 16'h0000, 1'b1, 1'b0));
        q.push_back(mk(1'b0, 6'd8,  16'h0,    1'b0, 16'h0008, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 6'd40, 16'h0,    1'b0, 16'h0000, 1'b1, 1'b0));
        q.push_back(mk(1'b1, 6'd12, 16'h0042, 1'b0, 16'h0042, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 6'd12, 16'h0,    1'b0, 16'h0042, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 6'd13, 16'h0,    1'b0, 16'h000D, 1'b0, 1'b0));
        q.push_back(mk(1'b1, 6'd13, 16'h7777, 1'b0, 16'h7777, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 6'd13, 16'h0,    1'b0, 16'h7777, 1'b0, 1'b0));
        run_q();

        // Reset while a write response is in flight
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd2; req_wdata = 16'hAAAA;
        @(negedge clk);
        chk("pre-reset lat1 rsp", 32'({rv1, rv2}), 32'd2);
        req_valid = 1'b0; req_we = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async reset clears rsp", 32'({rv1, rv2}), 32'd0);
        chk("async reset clears ready", 32'({rdy1, rdy2}), 32'd0);
        @(negedge clk);
        chk("in reset rsp", 32'({rv1, rv2}), 32'd0);
        rst_n = 1'b1;
        wait_init("mid-op reset");
        q.push_back(mk(1'b0, 6'd2,  16'h0, 1'b0, 16'h0002, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 6'd5,  16'h0, 1'b0, 16'h0005, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 6'd31, 16'h0, 1'b0, 16'h001F, 1'b0, 1'b0));
        run_q();

`ifdef DMEM_PARITY_EN
        // Injected parity error on addr 9, then a clean rewrite
        q.push_back(mk(1'b1, 6'd9,  16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 6'd9,  16'h0000, 1'b0, 16'h0001, 1'b0, 1'b1));
        q.push_back(mk(1'b0, 6'd50, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0));
        q.push_back(mk(1'b1, 6'd9,  16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 6'd9,  16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0));
        run_q();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised synchronous data memory with a valid/ready request port and a fixed-latency response port. It is the next generation of the processor's 32x16 data memory. After every reset it runs a self-initialisation sweep that loads mem[i] = i, then serves one read or write per cycle. It sits between the execute stage and data storage, replacing the combinational, latch-based memory.

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 6, request address width
DEPTH, 32, number of words; must satisfy DEPTH <= 2**ADDR_W
RD_LAT, 1, request-to-response latency in cycles; legal values are 1 or 2

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response valid, one-cycle pulse per accepted request
rsp_rdata  out  DATA_W  read data, or stored data for a write
rsp_err  out  1  accepted address was >= DEPTH
init_busy  out  1  initialisation sweep in progress

Behaviour:
- Reset (rst_n low, asynchronous):
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1.
  - FSM forced to INIT with the sweep counter at 0; the response pipeline is flushed.
- FSM state INIT:
  - Each cycle writes mem[cnt] = cnt (zero-extended or truncated to DATA_W), then increments cnt.
  - After the write of cnt = DEPTH-1 the FSM moves to RUN. INIT lasts exactly DEPTH cycles after rst_n rises.
  - req_ready=0 and init_busy=1 throughout INIT.
- FSM state RUN:
  - req_ready=1 and init_busy=0. RUN is the only state left, and only by reset.
  - Transfer occurs when req_valid && req_ready. Requests with req_valid=1 during INIT are not accepted; the requester holds them.
- Write:
  - mem[req_addr] <= req_wdata at the accept edge.
  - The response carries the newly stored value (write-through echo).
- Read:
  - The response carries mem[req_addr] as it stands after all earlier accepted writes.
  - A write at cycle N followed by a read of the same address at cycle N+1 returns the new data, with no bypass hazard.
- Latency: rsp_valid asserts exactly RD_LAT cycles after the accept edge, for both reads and writes.
- Throughput: fully pipelined, one request per cycle. The response port has no backpressure; the consumer must always take it.
- Out-of-range (req_addr >= DEPTH):
  - Write is ignored and memory is unchanged.
  - Response still issues on schedule with rsp_rdata=0 and rsp_err=1.
  - rsp_err=0 on all in-range responses.
- rsp_rdata and rsp_err hold their last values while rsp_valid=0 and are only meaningful when rsp_valid=1.
- Reset mid-operation: in-flight responses are discarded (no rsp_valid after rst_n rises until a new accept). Memory is fully re-initialised by a fresh INIT.
- Address arithmetic: unsigned. The INIT counter is ADDR_W+1 bits so DEPTH = 2**ADDR_W terminates correctly.
- Parameter check: RD_LAT outside {1,2} or DEPTH > 2**ADDR_W is a fatal elaboration error.

Optional Feature:
DMEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit, computed on INIT and on writes.
  - Adds input err_inject (1 bit); when high on a write accept, the stored parity bit is inverted.
  - Adds output rsp_perr (1 bit), reset 0. It is valid with rsp_valid and set when a read's recomputed parity mismatches the stored bit.
  - Write responses always report rsp_perr=0. Out-of-range reads report rsp_perr=0.
- Not defined: no parity storage, and neither err_inject nor rsp_perr exists on the port list.

Test Plan:
- Release rst_n -> init_busy=1 and req_ready=0 for exactly 32 cycles; then read addr 0..31 -> rsp_rdata = 0..31, each RD_LAT cycles after accept.
- Write 16'hBEEF to addr 5, read addr 5 in the next cycle -> responses 16'hBEEF then 16'hBEEF; a read of addr 6 still returns 6.
- Back-to-back reads of addr 3,4,7 with RD_LAT=2 -> rsp_valid high for 3 consecutive cycles with 3,4,7, starting 2 cycles after the first accept.
- Write 16'h1234 to addr 40, then read addr 40 -> both responses have rsp_err=1 and rsp_rdata=0; a read of addr 8 returns 8 (addr 40 did not alias to 8).
- Write 16'hAAAA to addr 2, pulse rst_n low during its response cycle -> no rsp_valid after release; after the 32-cycle INIT, read addr 2 returns 2.
- With DMEM_PARITY_EN: write 16'h0001 to addr 9 with err_inject=1, then read addr 9 -> rsp_rdata=16'h0001 and rsp_perr=1; a clean write and read of addr 9 -> rsp_perr=0.
